gpioemu_mulpop: RTL and testbench

GPIOEMU_MULPOP -- requirements
Module: gpioemu_mulpop

---
 rtl/gpioemu_mulpop.sv | 220 ++++++++++++++++++++++
 tb/tb_gpioemu_mulpop.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpioemu_mulpop.sv
// rtl/gpioemu_mulpop.sv - bus-mapped shift-add multiplier with popcount, op counter and GPIO capture
// Optional macro GPIOEMU_MULPOP_PRODHI_EN maps product[2*OP_W-1:32] at 0x0394.
module gpioemu_mulpop #(
  parameter int OP_W  = 24,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_out,
  output logic [31:0] gpio_in_s_insp
);

  localparam int PW = 2 * OP_W;

  localparam logic [15:0] ADDR_A1      = 16'h037F;
  localparam logic [15:0] ADDR_A2      = 16'h0388;
  localparam logic [15:0] ADDR_PROD_LO = 16'h0390;
  localparam logic [15:0] ADDR_PROD_HI = 16'h0394;
  localparam logic [15:0] ADDR_POP     = 16'h0398;
  localparam logic [15:0] ADDR_STATUS  = 16'h03A0;
  localparam logic [15:0] ADDR_CTRL    = 16'h03A1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_COUNT,
    S_DONE
  } state_e;

  state_e            state_q,     state_d;
  logic [OP_W-1:0]   a1_q,        a1_d;
  logic [OP_W-1:0]   a2_q,        a2_d;
  logic [PW-1:0]     mcand_q,     mcand_d;
  logic [OP_W-1:0]   mplier_q,    mplier_d;
  logic [PW-1:0]     product_q,   product_d;
  logic [5:0]        bit_cnt_q,   bit_cnt_d;
  logic [5:0]        pop_q,       pop_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              ready_q,     ready_d;
  logic              valid_q,     valid_d;
  logic              err_q,       err_d;
  logic              srd_prev_q,  srd_prev_d;
  logic              swr_prev_q,  swr_prev_d;
  logic [31:0]       gpio_in_s_q, gpio_in_s_d;
  logic [31:0]       sdata_out_q, sdata_out_d;

  logic        busy;
  logic        rd_edge;
  logic        wr_edge;
  logic        ctrl_wr;
  logic [63:0] prod64;
  logic [5:0]  pop_calc;
  logic [15:0] cnt16;
  logic        unused_sdata;

  assign busy    = (state_q != S_IDLE);
  assign rd_edge = srd & ~srd_prev_q;
  assign wr_edge = swr & ~swr_prev_q;
  assign ctrl_wr = wr_edge && (saddress == ADDR_CTRL);

  // Only the low OP_W bits and the two control bits are meaningful.
  assign unused_sdata = ^sdata_in;

  // Product zero-extended to 64 bits so word selects work for any OP_W.
  always_comb begin
    prod64           = '0;
    prod64[PW-1:0]   = product_q;
  end

  always_comb begin
    pop_calc = '0;
    for (int i = 0; i < 32; i++) begin
      pop_calc = pop_calc + {5'b0, prod64[i]};
    end
  end

  always_comb begin
    cnt16            = '0;
    cnt16[CNT_W-1:0] = cnt_q;
  end

  always_comb begin
    state_d     = state_q;
    a1_d        = a1_q;
    a2_d        = a2_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    product_d   = product_q;
    bit_cnt_d   = bit_cnt_q;
    pop_d       = pop_q;
    cnt_d       = cnt_q;
    ready_d     = ready_q;
    valid_d     = valid_q;
    err_d       = err_q;
    srd_prev_d  = srd;
    swr_prev_d  = swr;
    gpio_in_s_d = gpio_latch ? gpio_in : gpio_in_s_q;
    sdata_out_d = sdata_out_q;

    // Reads see pre-write state, so the mux uses only _q values.
    if (rd_edge) begin
      sdata_out_d = '0;
      case (saddress)
        ADDR_PROD_LO: if (!busy) sdata_out_d = prod64[31:0];
`ifdef GPIOEMU_MULPOP_PRODHI_EN
        ADDR_PROD_HI: if (!busy) sdata_out_d = prod64[63:32];
`endif
        ADDR_POP:     if (!busy) sdata_out_d = {26'b0, pop_q};
        ADDR_STATUS: begin
          sdata_out_d = {29'b0, err_q, ready_q, valid_q};
          err_d       = 1'b0;
        end
        default: ;
      endcase
    end

    if (wr_edge && !busy) begin
      if (saddress == ADDR_A1) a1_d = sdata_in[OP_W-1:0];
      if (saddress == ADDR_A2) a2_d = sdata_in[OP_W-1:0];
    end

    case (state_q)
      S_IDLE: begin
        if (ctrl_wr && sdata_in[0]) begin
          state_d   = S_MULT;
          mcand_d   = PW'(a1_q);
          mplier_d  = a2_q;
          product_d = '0;
          pop_d     = '0;
          bit_cnt_d = '0;
          ready_d   = 1'b0;
          valid_d   = 1'b0;
          err_d     = 1'b0;
        end
      end
      S_MULT: begin
        if (mplier_q[0]) product_d = product_q + mcand_q;
        mcand_d   = mcand_q << 1;
        mplier_d  = mplier_q >> 1;
        bit_cnt_d = bit_cnt_q + 6'd1;
        if (bit_cnt_q == 6'(OP_W - 1)) state_d = S_COUNT;
      end
      S_COUNT: begin
        pop_d   = pop_calc;
        state_d = S_DONE;
      end
      S_DONE: begin
        valid_d = (prod64[63:32] == 32'd0);
        ready_d = 1'b1;
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort outranks everything, including the DONE-cycle count increment.
    if (ctrl_wr && busy) begin
      if (sdata_in[1]) begin
        state_d   = S_IDLE;
        product_d = '0;
        pop_d     = '0;
        cnt_d     = cnt_q;
        ready_d   = 1'b1;
        valid_d   = 1'b0;
      end else if (sdata_in[0]) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      a1_q        <= '0;
      a2_q        <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      product_q   <= '0;
      bit_cnt_q   <= '0;
      pop_q       <= '0;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      srd_prev_q  <= 1'b0;
      swr_prev_q  <= 1'b0;
      gpio_in_s_q <= '0;
      sdata_out_q <= '0;
    end else begin
      state_q     <= state_d;
      a1_q        <= a1_d;
      a2_q        <= a2_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      product_q   <= product_d;
      bit_cnt_q   <= bit_cnt_d;
      pop_q       <= pop_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      srd_prev_q  <= srd_prev_d;
      swr_prev_q  <= swr_prev_d;
      gpio_in_s_q <= gpio_in_s_d;
      sdata_out_q <= sdata_out_d;
    end
  end

  assign sdata_out      = sdata_out_q;
  assign gpio_out       = {15'b0, busy, cnt16};
  assign gpio_in_s_insp = gpio_in_s_q;

endmodule

// File: tb/tb_gpioemu_mulpop.sv
// tb/tb_gpioemu_mulpop.sv - randomized self-checking bench for gpioemu_mulpop
// Honours GPIOEMU_MULPOP_PRODHI_EN when computing the 0x0394 expectation.
module tb_gpioemu_mulpop;

  localparam int OP_W  = 24;
  localparam int CNT_W = 2;

  localparam logic [15:0] A_A1     = 16'h037F;
  localparam logic [15:0] A_A2     = 16'h0388;
  localparam logic [15:0] A_PLO    = 16'h0390;
  localparam logic [15:0] A_PHI    = 16'h0394;
  localparam logic [15:0] A_POP    = 16'h0398;
  localparam logic [15:0] A_STATUS = 16'h03A0;
  localparam logic [15:0] A_CTRL   = 16'h03A1;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic [15:0] saddress = '0;
  logic        srd = 1'b0;
  logic        swr = 1'b0;
  logic [31:0] sdata_in = '0;
  logic [31:0] sdata_out;
  logic [31:0] gpio_in = '0;
  logic        gpio_latch = 1'b0;
  logic [31:0] gpio_out;
  logic [31:0] gpio_in_s_insp;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  gpioemu_mulpop #(.OP_W(OP_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .saddress       (saddress),
    .srd            (srd),
    .swr            (swr),
    .sdata_in       (sdata_in),
    .sdata_out      (sdata_out),
    .gpio_in        (gpio_in),
    .gpio_latch     (gpio_latch),
    .gpio_out       (gpio_out),
    .gpio_in_s_insp (gpio_in_s_insp)
  );

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b);
    return 64'(a) * 64'(b);
  endfunction

  function automatic logic [31:0] ref_pop(input logic [63:0] p);
    logic [31:0] lo;
    lo = p[31:0];
    return 32'($countones(lo));
  endfunction

  function automatic logic [31:0] ref_status(input logic [63:0] p);
    return (p[63:32] == 32'd0) ? 32'h3 : 32'h2;
  endfunction

  function automatic logic [31:0] ref_hi(input logic [63:0] p);
`ifdef GPIOEMU_MULPOP_PRODHI_EN
    return p[63:32];
`else
    return (p == 64'd0) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    @(negedge clk);
    saddress = a;
    sdata_in = d;
    swr      = 1'b1;
    @(negedge clk);
    swr      = 1'b0;
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk);
    saddress = a;
    srd      = 1'b1;
    @(negedge clk);
    srd      = 1'b0;
    d        = sdata_out;
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b);
    bus_write(A_A1, a);
    bus_write(A_A2, b);
    bus_write(A_CTRL, 32'h1);
    repeat (26) @(negedge clk);
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
  endtask

  task automatic test_reset;
    logic [31:0] d;
    n_reset = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (sdata_out !== 32'h0) begin n_fail++; $display("FAIL reset_sdata_out got=%h exp=%h", sdata_out, 32'h0); end
    n_checks++;
    if (gpio_out !== 32'h0) begin n_fail++; $display("FAIL reset_gpio_out got=%h exp=%h", gpio_out, 32'h0); end
    n_checks++;
    if (gpio_in_s_insp !== 32'h0) begin n_fail++; $display("FAIL reset_gpio_in_s got=%h exp=%h", gpio_in_s_insp, 32'h0); end
    n_reset = 1'b1;
    bus_read(A_STATUS, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL reset_status got=%h exp=%h", d, 32'h2); end
    n_checks++;
    if (gpio_out !== 32'h0) begin n_fail++; $display("FAIL reset_gpio_out2 got=%h exp=%h", gpio_out, 32'h0); end
  endtask

  task automatic test_basic;
    logic [31:0] d;
    bus_write(A_A1, 32'd3);
    bus_write(A_A2, 32'd5);
    bus_write(A_CTRL, 32'h1);
    repeat (25) @(negedge clk);
    n_checks++;
    if (gpio_out[16] !== 1'b1) begin n_fail++; $display("FAIL basic_busy_at_25 got=%b exp=1", gpio_out[16]); end
    @(negedge clk);
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    n_checks++;
    if (gpio_out !== 32'(exp_cnt)) begin n_fail++; $display("FAIL basic_gpio_out got=%h exp=%h", gpio_out, 32'(exp_cnt)); end
    bus_read(A_PLO, d);
    n_checks++;
    if (d !== 32'd15) begin n_fail++; $display("FAIL basic_prod got=%h exp=%h", d, 32'd15); end
    bus_read(A_POP, d);
    n_checks++;
    if (d !== 32'd4) begin n_fail++; $display("FAIL basic_pop got=%h exp=%h", d, 32'd4); end
    bus_read(A_STATUS, d);
    n_checks++;
    if (d !== 32'h3) begin n_fail++; $display("FAIL basic_status got=%h exp=%h", d, 32'h3); end
  endtask

  task automatic test_max;
    logic [31:0] d;
    logic [63:0] p;
    p = ref_prod(32'hFFFFFF, 32'hFFFFFF);
    run_op(32'hFFFFFF, 32'hFFFFFF);
    bus_read(A_PLO, d);
    n_checks++;
    if (d !== 32'hFE000001) begin n_fail++; $display("FAIL max_prod got=%h exp=%h", d, 32'hFE000001); end
    bus_read(A_POP, d);
    n_checks++;
    if (d !== 32'd8) begin n_fail++; $display("FAIL max_pop got=%h exp=%h", d, 32'd8); end
    bus_read(A_STATUS, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL max_status got=%h exp=%h", d, 32'h2); end
    bus_read(A_PHI, d);
    n_checks++;
    if (d !== ref_hi(p)) begin n_fail++; $display("FAIL max_prod_hi got=%h exp=%h", d, ref_hi(p)); end
  endtask

  task automatic test_random;
    logic [31:0] d, a, b;
    logic [63:0] p;
    for (int i = 0; i < 6; i++) begin
      a = $urandom & 32'hFFFFFF;
      b = $urandom & 32'hFFFFFF;
      if (i % 2 == 1) a = a & 32'hFF;
      p = ref_prod(a, b);
      run_op(a, b);
      bus_read(A_PLO, d);
      n_checks++;
      if (d !== p[31:0]) begin n_fail++; $display("FAIL rand_prod[%0d] a=%h b=%h got=%h exp=%h", i, a, b, d, p[31:0]); end
      bus_read(A_POP, d);
      n_checks++;
      if (d !== ref_pop(p)) begin n_fail++; $display("FAIL rand_pop[%0d] got=%h exp=%h", i, d, ref_pop(p)); end
      bus_read(A_STATUS, d);
      n_checks++;
      if (d !== ref_status(p)) begin n_fail++; $display("FAIL rand_status[%0d] got=%h exp=%h", i, d, ref_status(p)); end
      bus_read(A_PHI, d);
      n_checks++;
      if (d !== ref_hi(p)) begin n_fail++; $display("FAIL rand_prod_hi[%0d] got=%h exp=%h", i, d, ref_hi(p)); end
      n_checks++;
      if (gpio_out !== 32'(exp_cnt)) begin n_fail++; $display("FAIL rand_counter[%0d] got=%h exp=%h", i, gpio_out, 32'(exp_cnt)); end
    end
  endtask

  task automatic test_busy_rules;
    logic [31:0] d;
    bus_write(A_A1, 32'd7);
    bus_write(A_A2, 32'd9);
    bus_write(A_CTRL, 32'h1);
    bus_read(A_PLO, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL busy_prod_read got=%h exp=%h", d, 32'h0); end
    bus_write(A_A1, 32'd100);
    bus_write(A_CTRL, 32'h1);
    bus_read(A_STATUS, d);
    n_checks++;
    if (d !== 32'h4) begin n_fail++; $display("FAIL busy_err_status got=%h exp=%h", d, 32'h4); end
    bus_read(A_STATUS, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL busy_err_cleared got=%h exp=%h", d, 32'h0); end
    repeat (20) @(negedge clk);
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    bus_read(A_PLO, d);
    n_checks++;
    if (d !== 32'd63) begin n_fail++; $display("FAIL busy_result got=%h exp=%h", d, 32'd63); end
    bus_write(A_A2, 32'd2);
    bus_write(A_CTRL, 32'h1);
    repeat (26) @(negedge clk);
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    bus_read(A_PLO, d);
    n_checks++;
    if (d !== 32'd14) begin n_fail++; $display("FAIL busy_a1_write_ignored got=%h exp=%h", d, 32'd14); end
  endtask

  task automatic test_abort;
    logic [31:0] d;
    bus_write(A_CTRL, 32'h1);
    repeat (5) @(negedge clk);
    bus_write(A_CTRL, 32'h3);
    n_checks++;
    if (gpio_out !== 32'(exp_cnt)) begin n_fail++; $display("FAIL abort_gpio_out got=%h exp=%h", gpio_out, 32'(exp_cnt)); end
    bus_read(A_STATUS, d);
    n_checks++;
    if (d !== 32'h2) begin n_fail++; $display("FAIL abort_status got=%h exp=%h", d, 32'h2); end
    bus_read(A_PLO, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL abort_prod got=%h exp=%h", d, 32'h0); end
    bus_read(A_POP, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL abort_pop got=%h exp=%h", d, 32'h0); end
  endtask

  task automatic test_simul_rw;
    logic [31:0] d;
    @(negedge clk);
    saddress = A_CTRL;
    sdata_in = 32'h1;
    srd      = 1'b1;
    swr      = 1'b1;
    @(negedge clk);
    srd = 1'b0;
    swr = 1'b0;
    n_checks++;
    if (sdata_out !== 32'h0) begin n_fail++; $display("FAIL simul_read_value got=%h exp=%h", sdata_out, 32'h0); end
    n_checks++;
    if (gpio_out[16] !== 1'b1) begin n_fail++; $display("FAIL simul_write_started got=%b exp=1", gpio_out[16]); end
    repeat (26) @(negedge clk);
    exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    bus_read(A_PLO, d);
    n_checks++;
    if (d !== 32'd14) begin n_fail++; $display("FAIL simul_result got=%h exp=%h", d, 32'd14); end
  endtask

  task automatic test_unmapped;
    logic [31:0] d;
    bus_write(16'h0391, 32'hDEADBEEF);
    bus_write(A_STATUS, 32'hFFFFFFFF);
    bus_read(16'h1234, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got=%h exp=%h", d, 32'h0); end
    bus_read(A_A1, d);
    n_checks++;
    if (d !== 32'h0) begin n_fail++; $display("FAIL a1_readback got=%h exp=%h", d, 32'h0); end
    bus_read(A_PLO, d);
    n_checks++;
    if (d !== 32'd14) begin n_fail++; $display("FAIL unmapped_write_effect got=%h exp=%h", d, 32'd14); end
    n_checks++;
    if (gpio_out !== 32'(exp_cnt)) begin n_fail++; $display("FAIL unmapped_counter got=%h exp=%h", gpio_out, 32'(exp_cnt)); end
  endtask

  task automatic test_gpio;
    logic [31:0] exp_s;
    exp_s = gpio_in_s_insp;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      gpio_in    = $urandom;
      gpio_latch = (i % 3 != 1);
      if (gpio_latch) exp_s = gpio_in;
      @(negedge clk);
      n_checks++;
      if (gpio_in_s_insp !== exp_s) begin n_fail++; $display("FAIL gpio_capture[%0d] got=%h exp=%h", i, gpio_in_s_insp, exp_s); end
    end
    gpio_latch = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    @(negedge clk);
    gpio_in    = 32'hA5A5_0F0F;
    gpio_latch = 1'b1;
    @(negedge clk);
    gpio_latch = 1'b0;
    bus_read(A_STATUS, d);
    bus_write(A_CTRL, 32'h1);
    repeat (10) @(negedge clk);
    #2;
    n_reset = 1'b0;
    #1;
    exp_cnt = 0;
    n_checks++;
    if (sdata_out !== 32'h0) begin n_fail++; $display("FAIL midreset_sdata_out got=%h exp=%h", sdata_out, 32'h0); end
    n_checks++;
    if (gpio_out !== 32'h0) begin n_fail++; $display("FAIL midreset_gpio_out got=%h exp=%h", gpio_out, 32'h0); end
    n_checks++;
    if (gpio_in_s_insp !== 32'h0) begin n_fail++; $display("FAIL midreset_gpio_in_s got=%h exp=%h", gpio_in_s_insp, 32'h0); end
    saddress = A_STATUS;
    srd      = 1'b1;
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (sdata_out !== 32'h2) begin n_fail++; $display("FAIL first_strobe_after_reset got=%h exp=%h", sdata_out, 32'h2); end
    srd = 1'b0;
  endtask

  task automatic test_wrap;
    logic [31:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a = $urandom & 32'hFFF;
      b = $urandom & 32'hFFF;
      run_op(a, b);
      n_checks++;
      if (gpio_out !== 32'(exp_cnt)) begin n_fail++; $display("FAIL wrap_counter[%0d] got=%h exp=%h", i, gpio_out, 32'(exp_cnt)); end
    end
    n_checks++;
    if (gpio_out[15:0] !== 16'h0) begin n_fail++; $display("FAIL wrap_to_zero got=%h exp=%h", gpio_out[15:0], 16'h0); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_max;
    test_random;
    test_busy_rules;
    test_abort;
    test_simul_rw;
    test_unmapped;
    test_gpio;
    test_reset_mid;
    test_wrap;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
